rename_regfile: RTL and testbench
=================================

RENAME_REGFILE -- requirements
Module: rename_regfile

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  XLEN  32  data width
  TAG_W  4  rename (ROB) tag width
  NCMT  2  commit ports; port i+1 is younger in program order than port i
REQ-002 Ports (name  direction  width  meaning), one per line:
  clk  in  1  single clock; all state changes on its rising edge
  rst  in  1  reset, synchronous, active-high
  rdy  in  1  global enable; low = hold all state and outputs
  cmt_valid  in  NCMT  commit port valid, one bit per port
  cmt_rd  in  NCMT*5  commit destination register
  cmt_tag  in  NCMT*TAG_W  rename tag of committing instruction
  cmt_data  in  NCMT*XLEN  commit value
  flush  in  1  misprediction flush
  req_valid  in  1  rename request
  req_id  in  TAG_W  new instruction tag; also the tag given to its rd
  req_rd_en  in  1  instruction writes rd
  req_rd  in  5  destination register
  req_src_en  in  2  source operand enables
  req_src  in  10  source registers, {src1,src0}
  rsp_valid  out  1  lookup result valid
  rsp_id  out  TAG_W  echo of req_id
  rsp_busy  out  2  per source: value pending
  rsp_tag  out  2*TAG_W  per source: producer tag, meaningful only when busy
  rsp_data  out  2*XLEN  per source: value, meaningful only when not busy

Function
REQ-003 State: 32 entries, each with value[XLEN], busy, tag[TAG_W].
REQ-004 Register x0 SHALL never be busy, SHALL always read 0, and SHALL ignore commit and rename writes.
REQ-005 Response latency SHALL be 1 cycle: req_valid&rdy&!flush in cycle N gives rsp_valid=1 in cycle N+1; otherwise rsp_valid=0 in cycle N+1 (when rdy=1).
REQ-006 Per enabled source s, in priority order:
  (a) s=0 -> busy 0, data 0.
  (b) A same-cycle commit port with cmt_rd=s, cmt_tag=tag[s], and busy[s]=1 -> busy 0, data from that port; if several ports match, the highest-index port wins.
  (c) busy[s]=1 -> busy 1, tag[s].
  (d) Otherwise -> busy 0, value[s].
REQ-007 A disabled source SHALL return busy 0, tag 0, data 0.
REQ-008 Source lookup SHALL use state from before this cycle's rename: with rd=src, the source sees the older producer.
REQ-009 Commit on port i (rd≠0): value[rd] <= cmt_data[i] unconditionally. busy[rd] clears only if cmt_tag[i]=tag[rd] and no same-cycle rename of rd occurs.
REQ-010 Several commit ports with the same rd in one cycle: the highest-index port's value SHALL be written; busy clears if any matching port satisfies REQ-009.
REQ-011 Rename (req_valid, req_rd_en, req_rd≠0, no flush): busy[rd] <= 1, tag[rd] <= req_id. Rename SHALL override any same-cycle busy clear on rd.
REQ-012 flush SHALL clear all busy bits and suppress that cycle's request (no rename, rsp_valid=0 next cycle). Same-cycle commits SHALL still write their values.
REQ-013 With rdy=0, all state and outputs SHALL hold, including rsp_valid.
REQ-014 Tags SHALL compare as exact TAG_W-bit equality; tag wrap-around needs no special handling.

Reset
REQ-015 On rst=1 at a clock edge, regardless of rdy or any in-flight request: all value, busy, and tag fields become 0; rsp_valid, rsp_id, rsp_busy, rsp_tag, and rsp_data become 0.
REQ-016 A request presented in the same cycle as rst SHALL be discarded.

Verification
REQ-017 Rename x5 with tag 3, then look up x5 next cycle -> rsp_busy[0]=1, rsp_tag=3.
REQ-018 x5 busy with tag 3. Commit port 0 (x5, tag 3, 0xDEADBEEF) in the same cycle as a src0=x5 lookup -> next cycle busy 0, data 0xDEADBEEF. A later lookup also gives not busy with 0xDEADBEEF.
REQ-019 x7 renamed with tag 2, then with tag 4. Commit (x7, tag 2, 0x11) -> x7 stays busy with tag 4, value 0x11. Same-cycle ports 0 and 1 both commit x7 with 0x1 and 0x2 -> value 0x2.
REQ-020 Request src0=x9, rd=x9, tag 6, while x9 is idle with value 0x55 -> response not busy, 0x55. After that, x9 is busy with tag 6.
REQ-021 Several registers busy, then flush together with a rename request of x3 -> all busy bits 0, x3 not busy, rsp_valid=0 next cycle.
REQ-022 Try to rename x0 and commit x0 with 0xFF, then look up x0 -> busy 0, data 0. With rdy=0 for 3 cycles, every output is unchanged.

Source files
------------

// File: rtl/rename_regfile.sv
// Rename-aware architectural register file.
// Holds 32 entries of {value, busy, producer tag}. Each cycle it can take up to NCMT
// commits and one rename request. The request looks up two source operands and the
// answer is registered, so it appears one cycle later. The lookup uses the state as
// it was before this cycle's rename. A same-cycle commit whose tag matches is
// forwarded to the lookup.
module rename_regfile #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4,
    parameter int NCMT  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic [NCMT-1:0]       cmt_valid,
    input  logic [NCMT*5-1:0]     cmt_rd,
    input  logic [NCMT*TAG_W-1:0] cmt_tag,
    input  logic [NCMT*XLEN-1:0]  cmt_data,
    input  logic                  flush,
    input  logic                  req_valid,
    input  logic [TAG_W-1:0]      req_id,
    input  logic                  req_rd_en,
    input  logic [4:0]            req_rd,
    input  logic [1:0]            req_src_en,
    input  logic [9:0]            req_src,
    output logic                  rsp_valid,
    output logic [TAG_W-1:0]      rsp_id,
    output logic [1:0]            rsp_busy,
    output logic [2*TAG_W-1:0]    rsp_tag,
    output logic [2*XLEN-1:0]     rsp_data
);
    localparam int NREG = 32;

    logic [XLEN-1:0]  value_reg [NREG];
    logic [NREG-1:0]  busy_reg;
    logic [TAG_W-1:0] tag_reg   [NREG];

    // Commit ports unpacked into arrays for readability.
    logic [4:0]       cmt_rd_a   [NCMT];
    logic [TAG_W-1:0] cmt_tag_a  [NCMT];
    logic [XLEN-1:0]  cmt_data_a [NCMT];

    for (genvar gi = 0; gi < NCMT; gi++) begin : g_cmt_unpack
        assign cmt_rd_a[gi]   = cmt_rd[gi*5 +: 5];
        assign cmt_tag_a[gi]  = cmt_tag[gi*TAG_W +: TAG_W];
        assign cmt_data_a[gi] = cmt_data[gi*XLEN +: XLEN];
    end

    // A flush suppresses the request. A request that renames x0 changes no state.
    logic req_fire;
    logic rename_fire;
    assign req_fire    = req_valid & ~flush;
    assign rename_fire = req_fire & req_rd_en & (req_rd != 5'd0);

    // Per-source lookup with commit forwarding. Results are registered below.
    logic [1:0]         src_busy_next;
    logic [2*TAG_W-1:0] src_tag_next;
    logic [2*XLEN-1:0]  src_data_next;

    for (genvar gi = 0; gi < 2; gi++) begin : g_src
        logic [4:0]       idx;
        logic             hit;
        logic [XLEN-1:0]  hit_data;
        logic             busy_s;
        logic [TAG_W-1:0] tag_s;
        logic [XLEN-1:0]  data_s;

        assign idx = req_src[gi*5 +: 5];

        // Resolve the source. When several ports match, the later port wins because
        // the loop visits it last.
        always_comb begin
            hit      = 1'b0;
            hit_data = '0;
            busy_s   = 1'b0;
            tag_s    = '0;
            data_s   = '0;
            for (int p = 0; p < NCMT; p++) begin
                if (cmt_valid[p] && (cmt_rd_a[p] == idx) &&
                    (cmt_tag_a[p] == tag_reg[idx]) && busy_reg[idx]) begin
                    hit      = 1'b1;
                    hit_data = cmt_data_a[p];
                end
            end
            if (req_src_en[gi] && (idx != 5'd0)) begin
                if (hit) begin
                    data_s = hit_data;
                end else if (busy_reg[idx]) begin
                    busy_s = 1'b1;
                    tag_s  = tag_reg[idx];
                end else begin
                    data_s = value_reg[idx];
                end
            end
        end

        assign src_busy_next[gi]                = busy_s;
        assign src_tag_next[gi*TAG_W +: TAG_W]  = tag_s;
        assign src_data_next[gi*XLEN +: XLEN]   = data_s;
    end

    // Per-register commit effects. The value comes from the highest matching port.
    // Busy clears if any matching port carries the current producer tag.
    logic [NREG-1:0] val_wr_next;
    logic [XLEN-1:0] val_din_next [NREG];
    logic [NREG-1:0] clr_next;

    // Decode the commit ports into per-register write and clear requests. x0 never
    // takes a write.
    always_comb begin
        val_wr_next = '0;
        clr_next    = '0;
        for (int r = 0; r < NREG; r++) begin
            val_din_next[r] = '0;
        end
        for (int r = 1; r < NREG; r++) begin
            for (int p = 0; p < NCMT; p++) begin
                if (cmt_valid[p] && (cmt_rd_a[p] == 5'(r))) begin
                    val_wr_next[r]  = 1'b1;
                    val_din_next[r] = cmt_data_a[p];
                    if (cmt_tag_a[p] == tag_reg[r]) begin
                        clr_next[r] = 1'b1;
                    end
                end
            end
        end
    end

    // State update. Reset takes priority over rdy. A flush clears every busy bit and
    // still lets commit values land. A rename takes priority over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                value_reg[r] <= '0;
                tag_reg[r]   <= '0;
            end
            busy_reg  <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_busy  <= '0;
            rsp_tag   <= '0;
            rsp_data  <= '0;
        end else if (rdy) begin
            for (int r = 1; r < NREG; r++) begin
                if (val_wr_next[r]) begin
                    value_reg[r] <= val_din_next[r];
                end
                if (flush) begin
                    busy_reg[r] <= 1'b0;
                end else if (rename_fire && (req_rd == 5'(r))) begin
                    busy_reg[r] <= 1'b1;
                    tag_reg[r]  <= req_id;
                end else if (clr_next[r]) begin
                    busy_reg[r] <= 1'b0;
                end
            end
            rsp_valid <= req_fire;
            if (req_fire) begin
                rsp_id   <= req_id;
                rsp_busy <= src_busy_next;
                rsp_tag  <= src_tag_next;
                rsp_data <= src_data_next;
            end
        end
    end
endmodule

// File: tb/tb_rename_regfile.sv
// Directed bench for rename_regfile. The expected values are worked out by hand.
module tb_rename_regfile;
    localparam int XLEN  = 32;
    localparam int TAG_W = 4;
    localparam int NCMT  = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  rdy;
    logic [NCMT-1:0]       cmt_valid;
    logic [NCMT*5-1:0]     cmt_rd;
    logic [NCMT*TAG_W-1:0] cmt_tag;
    logic [NCMT*XLEN-1:0]  cmt_data;
    logic                  flush;
    logic                  req_valid;
    logic [TAG_W-1:0]      req_id;
    logic                  req_rd_en;
    logic [4:0]            req_rd;
    logic [1:0]            req_src_en;
    logic [9:0]            req_src;
    logic                  rsp_valid;
    logic [TAG_W-1:0]      rsp_id;
    logic [1:0]            rsp_busy;
    logic [2*TAG_W-1:0]    rsp_tag;
    logic [2*XLEN-1:0]     rsp_data;

    int n_checks = 0;
    int n_fail   = 0;

    rename_regfile #(.XLEN(XLEN), .TAG_W(TAG_W), .NCMT(NCMT)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .cmt_valid(cmt_valid), .cmt_rd(cmt_rd), .cmt_tag(cmt_tag), .cmt_data(cmt_data),
        .flush(flush), .req_valid(req_valid), .req_id(req_id), .req_rd_en(req_rd_en),
        .req_rd(req_rd), .req_src_en(req_src_en), .req_src(req_src),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_busy(rsp_busy),
        .rsp_tag(rsp_tag), .rsp_data(rsp_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic idle();
        rst = 1'b0; rdy = 1'b1; flush = 1'b0;
        cmt_valid = '0; cmt_rd = '0; cmt_tag = '0; cmt_data = '0;
        req_valid = 1'b0; req_id = '0; req_rd_en = 1'b0; req_rd = '0;
        req_src_en = '0; req_src = '0;
    endtask

    // Advance one clock. Outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [3:0] id, input logic rd_en, input logic [4:0] rd,
                       input logic [1:0] en, input logic [4:0] s1, input logic [4:0] s0);
        req_valid = 1'b1; req_id = id; req_rd_en = rd_en; req_rd = rd;
        req_src_en = en; req_src = {s1, s0};
    endtask

    task automatic cmt(input int p, input logic [4:0] rd, input logic [3:0] tag,
                       input logic [31:0] data);
        cmt_valid[p] = 1'b1;
        cmt_rd[p*5 +: 5] = rd;
        cmt_tag[p*TAG_W +: TAG_W] = tag;
        cmt_data[p*XLEN +: XLEN] = data;
    endtask

    initial begin
        idle();
        // Reset with a request present; the request must be discarded.
        rst = 1'b1;
        req(4'd1, 1'b1, 5'd4, 2'b01, 5'd0, 5'd4);
        step();
        $display("reset with request discarded");
        chk("rst_valid", 64'(rsp_valid), 64'd0);
        chk("rst_id",    64'(rsp_id),    64'd0);
        chk("rst_busy",  64'(rsp_busy),  64'd0);
        chk("rst_tag",   64'(rsp_tag),   64'd0);
        chk("rst_data",  rsp_data,       64'd0);
        idle(); step();
        chk("idle_valid", 64'(rsp_valid), 64'd0);

        // Rename x5 with tag 3, then look up x5.
        req(4'd3, 1'b1, 5'd5, 2'b00, 5'd0, 5'd0); step(); idle();
        $display("rename x5 tag 3");
        chk("ren_valid", 64'(rsp_valid), 64'd1);
        chk("ren_id",    64'(rsp_id),    64'd3);
        chk("ren_dis",   64'({rsp_busy, rsp_tag}), 64'd0);
        req(4'd1, 1'b0, 5'd0, 2'b01, 5'd0, 5'd5); step(); idle();
        $display("lookup x5");
        chk("x5_busy", 64'(rsp_busy[0]),  64'd1);
        chk("x5_tag",  64'(rsp_tag[3:0]), 64'd3);

        // Commit x5 and look it up in the same cycle, then look it up again.
        req(4'd2, 1'b0, 5'd0, 2'b01, 5'd0, 5'd5);
        cmt(0, 5'd5, 4'd3, 32'hDEADBEEF); step(); idle();
        $display("lookup x5 with same-cycle commit");
        chk("byp_busy", 64'(rsp_busy[0]),    64'd0);
        chk("byp_data", 64'(rsp_data[31:0]), 64'hDEADBEEF);
        req(4'd3, 1'b0, 5'd0, 2'b01, 5'd0, 5'd5); step(); idle();
        $display("lookup x5 later");
        chk("x5c_busy", 64'(rsp_busy[0]),    64'd0);
        chk("x5c_data", 64'(rsp_data[31:0]), 64'hDEADBEEF);

        // Rename x7 with tag 2 then tag 4. A commit with tag 2 leaves x7 busy.
        req(4'd2, 1'b1, 5'd7, 2'b00, 5'd0, 5'd0); step(); idle();
        req(4'd4, 1'b1, 5'd7, 2'b00, 5'd0, 5'd0); step(); idle();
        cmt(0, 5'd7, 4'd2, 32'h11); step(); idle();
        req(4'd5, 1'b0, 5'd0, 2'b10, 5'd7, 5'd0); step(); idle();
        $display("x7 after stale commit");
        chk("x7_busy", 64'(rsp_busy[1]),  64'd1);
        chk("x7_tag",  64'(rsp_tag[7:4]), 64'd4);
        // Flush the pending rename. The stale commit's value must become visible.
        flush = 1'b1; step(); idle();
        req(4'd6, 1'b0, 5'd0, 2'b10, 5'd7, 5'd0); step(); idle();
        $display("x7 value after flush");
        chk("x7_val_busy", 64'(rsp_busy[1]),     64'd0);
        chk("x7_val",      64'(rsp_data[63:32]), 64'h11);
        // Rename again. Both ports commit x7 together; port 1 must win.
        req(4'd4, 1'b1, 5'd7, 2'b00, 5'd0, 5'd0); step(); idle();
        req(4'd7, 1'b0, 5'd0, 2'b01, 5'd0, 5'd7);
        cmt(0, 5'd7, 4'd4, 32'h1); cmt(1, 5'd7, 4'd4, 32'h2); step(); idle();
        $display("x7 dual commit forwarded");
        chk("dual_byp_busy", 64'(rsp_busy[0]),    64'd0);
        chk("dual_byp_data", 64'(rsp_data[31:0]), 64'h2);
        req(4'd8, 1'b0, 5'd0, 2'b01, 5'd0, 5'd7); step(); idle();
        $display("x7 after dual commit");
        chk("dual_busy", 64'(rsp_busy[0]),    64'd0);
        chk("dual_data", 64'(rsp_data[31:0]), 64'h2);

        // Look up x9 and rename it in the same request; the lookup sees the old value.
        cmt(0, 5'd9, 4'd0, 32'h55); step(); idle();
        req(4'd6, 1'b1, 5'd9, 2'b01, 5'd0, 5'd9); step(); idle();
        $display("x9 src=rd");
        chk("x9_busy", 64'(rsp_busy[0]),    64'd0);
        chk("x9_data", 64'(rsp_data[31:0]), 64'h55);
        req(4'd9, 1'b0, 5'd0, 2'b01, 5'd0, 5'd9); step(); idle();
        $display("x9 renamed");
        chk("x9r_busy", 64'(rsp_busy[0]),  64'd1);
        chk("x9r_tag",  64'(rsp_tag[3:0]), 64'd6);

        // With x9 and x10 busy, flush arrives together with a rename of x3.
        req(4'd7, 1'b1, 5'd10, 2'b00, 5'd0, 5'd0); step(); idle();
        flush = 1'b1; req(4'd5, 1'b1, 5'd3, 2'b01, 5'd0, 5'd3); step(); idle();
        $display("flush with rename x3");
        chk("flush_valid", 64'(rsp_valid), 64'd0);
        req(4'd10, 1'b0, 5'd0, 2'b11, 5'd10, 5'd9); step(); idle();
        $display("x9/x10 after flush");
        chk("fl_busy",  64'(rsp_busy),       64'd0);
        chk("fl_data",  rsp_data,            {32'h0, 32'h55});
        req(4'd11, 1'b0, 5'd0, 2'b01, 5'd0, 5'd3); step(); idle();
        chk("x3_busy",  64'(rsp_busy[0]),    64'd0);

        // Writes to x0 must have no effect.
        req(4'd8, 1'b1, 5'd0, 2'b00, 5'd0, 5'd0); cmt(0, 5'd0, 4'd8, 32'hFF); step(); idle();
        req(4'd12, 1'b0, 5'd0, 2'b11, 5'd0, 5'd0); step(); idle();
        $display("x0 lookup");
        chk("x0_busy", 64'(rsp_busy), 64'd0);
        chk("x0_data", rsp_data,      64'd0);

        // rdy low for 3 cycles. Outputs and state must hold.
        req(4'd9, 1'b0, 5'd0, 2'b01, 5'd0, 5'd9); step(); idle();
        for (int i = 0; i < 3; i++) begin
            rdy = 1'b0;
            req(4'd13, 1'b1, 5'd9, 2'b11, 5'd5, 5'd7);
            cmt(0, 5'd9, 4'd0, 32'h77);
            step();
            $display("rdy low cycle %0d", i);
            chk("hold_valid", 64'(rsp_valid), 64'd1);
            chk("hold_id",    64'(rsp_id),    64'd9);
            chk("hold_busy",  64'(rsp_busy),  64'd0);
            chk("hold_data",  rsp_data,       64'h55);
        end
        idle();
        req(4'd14, 1'b0, 5'd0, 2'b01, 5'd0, 5'd9); step(); idle();
        $display("x9 after rdy low");
        chk("held_busy", 64'(rsp_busy[0]),    64'd0);
        chk("held_data", 64'(rsp_data[31:0]), 64'h55);

        // Reset while rdy is low clears everything.
        rst = 1'b1; rdy = 1'b0; step(); idle();
        $display("reset with rdy low");
        chk("rst2_valid", 64'(rsp_valid), 64'd0);
        req(4'd15, 1'b0, 5'd0, 2'b01, 5'd0, 5'd9); step(); idle();
        chk("rst2_data", rsp_data, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
